// File: rtl/alu_pkg.sv
// alu_pkg: shared op and state encodings for the serial ALU
package alu_pkg;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
endpackage

// File: rtl/alu_slice_1bit.sv
// alu_slice_1bit: one-bit full-adder/logic slice reused each cycle by the serial ALU
module alu_slice_1bit
    import alu_pkg::*;
(
    input  logic       ai,
    input  logic       bi,
    input  logic       cin,
    input  logic [2:0] op,
    output logic       r,
    output logic       cout
);
    logic arith;
    always_comb begin
        arith = (op == OP_ADD) || (op == OP_SUB);
        r = arith           ? ai ^ bi ^ cin :
            (op == OP_AND)  ? ai & bi :
            (op == OP_OR)   ? ai | bi :
            (op == OP_NOR)  ? ~(ai | bi) :
            (op == OP_XOR)  ? ai ^ bi : 1'b0;
        cout = arith ? (ai & bi) | (ai & cin) | (bi & cin) : cin;
    end
endmodule

// File: rtl/serial_alu.sv
// serial_alu: bit-serial ALU processing WIDTH-bit operands LSB first with a start/done handshake
module serial_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    state_t state, nxt;
    logic [WIDTH-1:0] shreg_a, shreg_b, acc;
    logic [2:0] op_q;
    logic [CW-1:0] cnt;
    logic c, nonzero, ai, bi, r, cout, arith;
    alu_slice_1bit u_slice (.ai(ai), .bi(bi), .cin(c), .op(op_q), .r(r), .cout(cout));
    always_comb begin
        ai = shreg_a[0];
        bi = shreg_b[0] ^ (op_q == OP_SUB);
        arith = (op_q == OP_ADD) || (op_q == OP_SUB);
        busy = state == S_SHIFT;
        done = state == S_DONE;
        nxt = (state == S_IDLE)  ? (start ? S_SHIFT : S_IDLE) :
              (state == S_SHIFT) ? ((cnt == LAST) ? S_DONE : S_SHIFT) : S_IDLE;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= S_IDLE;
        else state <= nxt;
    // result/zero/carry_out update only on the edge that enters DONE, folding in the last slice output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_a <= '0;
            shreg_b <= '0;
            acc <= '0;
            op_q <= OP_ADD;
            cnt <= '0;
            c <= 1'b0;
            nonzero <= 1'b0;
            result <= '0;
            carry_out <= 1'b0;
            zero <= 1'b1;
        end else if (state == S_IDLE && start) begin
            shreg_a <= a;
            shreg_b <= b;
            op_q <= op;
            cnt <= '0;
            nonzero <= 1'b0;
            c <= (op == OP_SUB);
        end else if (state == S_SHIFT) begin
            shreg_a <= shreg_a >> 1;
            shreg_b <= shreg_b >> 1;
            acc <= {r, acc[WIDTH-1:1]};
            nonzero <= nonzero | r;
            c <= cout;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
                result <= {r, acc[WIDTH-1:1]};
                zero <= ~(nonzero | r);
                carry_out <= arith & cout;
            end
        end
    end
endmodule

// File: tb/tb_serial_alu.sv
// tb_serial_alu: directed self-checking bench for serial_alu
module tb_serial_alu;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [2:0] op = 3'b000;
    logic [7:0] a = '0, b = '0;
    logic busy, done, carry_out, zero;
    logic [7:0] result;
    int tests = 0, fails = 0;

    serial_alu #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .carry_out(carry_out), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_op(input string tag, input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] er, input logic ec, input logic ez);
        int cycles, busy_cnt;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        cycles = 1;
        busy_cnt = 0;
        while (!done && cycles < 20) begin
            busy_cnt += busy;
            @(negedge clk);
            cycles++;
        end
        check({tag, " latency"}, cycles, 9);
        check({tag, " busy_cycles"}, busy_cnt, 8);
        check({tag, " result"}, result, er);
        check({tag, " carry"}, carry_out, ec);
        check({tag, " zero"}, zero, ez);
        @(negedge clk);
        check({tag, " done_pulse"}, done, 0);
    endtask

    initial begin
        int dones;
        logic [7:0] seen;
        repeat (2) @(negedge clk);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst result", result, 8'h00);
        check("rst carry", carry_out, 0);
        check("rst zero", zero, 1);
        rst = 1'b0;

        do_op("add7f", 3'b000, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0);
        do_op("addff", 3'b000, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1);
        do_op("sub55", 3'b001, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1);
        do_op("sub35", 3'b001, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0);
        do_op("nor1",  3'b100, 8'hF0, 8'h0F, 8'h00, 1'b0, 1'b1);
        do_op("nor0",  3'b100, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0);
        do_op("and",   3'b010, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0);
        do_op("or",    3'b011, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0);
        do_op("xor",   3'b101, 8'hAA, 8'hFF, 8'h55, 1'b0, 1'b0);
        do_op("rsvd",  3'b110, 8'hAA, 8'hFF, 8'h00, 1'b0, 1'b1);

        // start pulse during SHIFT must be ignored
        @(negedge clk);
        start = 1'b1; op = 3'b000; a = 8'h01; b = 8'h01;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; a = 8'h10; b = 8'h10;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        seen = 8'h00;
        repeat (14) begin
            if (done) begin
                dones++;
                seen = result;
            end
            @(negedge clk);
        end
        check("ign done_count", dones, 1);
        check("ign result", seen, 8'h02);
        check("ign result_held", result, 8'h02);
        check("ign idle", busy, 0);

        // asynchronous reset mid-operation
        @(negedge clk);
        start = 1'b1; op = 3'b000; a = 8'h7F; b = 8'h01;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid busy_before", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("arst busy", busy, 0);
        check("arst done", done, 0);
        check("arst result", result, 8'h00);
        check("arst zero", zero, 1);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        repeat (12) begin
            dones += done;
            @(negedge clk);
        end
        check("arst no_done", dones, 0);
        do_op("post_rst", 3'b000, 8'h03, 8'h04, 8'h07, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
